// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with IF/ID register, stall hold and four-way next-PC select.
// Optional IF_FLUSH_EN: squash the sequential fetch on a redirect instead of delay-slot semantics.
module if_stage_pipe #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       IMEM_AW  = 6,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [31:0]       NOP_WORD = 32'h0
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               stall,
   input  logic [1:0]         pcsource,
   input  logic [ADDR_W-1:0]  bpc,
   input  logic [ADDR_W-1:0]  jpc,
   input  logic [ADDR_W-1:0]  rpc,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc4,
   output logic [31:0]        id_inst,
   output logic               id_valid,
   output logic [15:0]        bubble_cnt
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] next_pc;
   logic              load_bubble;

   assign pc4       = pc + ADDR_W'(4);
   assign imem_addr = pc[IMEM_AW+1:2];

   always_comb begin
      target = rpc;
      case (pcsource)
         2'b01:   target = bpc;
         2'b10:   target = jpc;
         default: target = rpc;
      endcase
      // redirect targets are word-aligned regardless of what ID hands us
      next_pc = (pcsource == 2'b00) ? pc4 : (target & ALIGN_MASK);
   end

`ifdef IF_FLUSH_EN
   assign load_bubble = (pcsource != 2'b00);
`else
   assign load_bubble = 1'b0;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pc         <= RESET_PC;
         id_pc      <= '0;
         id_pc4     <= '0;
         id_inst    <= NOP_WORD;
         id_valid   <= 1'b0;
         bubble_cnt <= '0;
      end else if (!stall) begin
         pc     <= next_pc;
         id_pc  <= pc;
         id_pc4 <= pc4;
         if (load_bubble) begin
            id_inst  <= NOP_WORD;
            id_valid <= 1'b0;
            if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
         end else begin
            id_inst  <= imem_data;
            id_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Scoreboard bench for if_stage_pipe: reference model pushes expected state per edge,
// monitor pops and compares after each rising edge; tasks add targeted inline checks.
module tb_if_stage_pipe;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  pcsource = 2'b00;
   logic [31:0] bpc = '0, jpc = '0, rpc = '0;
   logic [5:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] pc, id_pc, id_pc4, id_inst;
   logic        id_valid;
   logic [15:0] bubble_cnt;

   logic [5:0]  imem_addr8;
   logic [31:0] imem_data8;
   logic [7:0]  pc8, id_pc8, id_pc48;
   logic [31:0] id_inst8;
   logic        id_valid8;
   logic [15:0] bubble_cnt8;

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [5:0] a);
      return 32'hC0DE_0000 | {26'd0, a};
   endfunction

   assign imem_data  = word_at(imem_addr);
   assign imem_data8 = word_at(imem_addr8);

   if_stage_pipe #(.ADDR_W(32), .IMEM_AW(6), .RESET_PC(32'h40), .NOP_WORD(NOP)) dut (
      .clk(clk), .clr(clr), .stall(stall), .pcsource(pcsource),
      .bpc(bpc), .jpc(jpc), .rpc(rpc),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .pc(pc), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
      .id_valid(id_valid), .bubble_cnt(bubble_cnt)
   );

   if_stage_pipe #(.ADDR_W(8), .IMEM_AW(6), .RESET_PC(8'hF8), .NOP_WORD(NOP)) dut8 (
      .clk(clk), .clr(clr), .stall(1'b0), .pcsource(2'b00),
      .bpc(8'h00), .jpc(8'h00), .rpc(8'h00),
      .imem_addr(imem_addr8), .imem_data(imem_data8),
      .pc(pc8), .id_pc(id_pc8), .id_pc4(id_pc48), .id_inst(id_inst8),
      .id_valid(id_valid8), .bubble_cnt(bubble_cnt8)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] id_pc;
      logic [31:0] id_pc4;
      logic [31:0] id_inst;
      logic        id_valid;
      logic [15:0] bub;
   } st_t;

   st_t m;
   st_t q[$];
   int  checks = 0;
   int  errors = 0;

   // scoreboard monitor
   always @(posedge clk) begin
      st_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++; if (pc !== e.pc) begin errors++; $display("FAIL sb_pc got %h exp %h", pc, e.pc); end
         checks++; if (id_pc !== e.id_pc) begin errors++; $display("FAIL sb_id_pc got %h exp %h", id_pc, e.id_pc); end
         checks++; if (id_pc4 !== e.id_pc4) begin errors++; $display("FAIL sb_id_pc4 got %h exp %h", id_pc4, e.id_pc4); end
         checks++; if (id_inst !== e.id_inst) begin errors++; $display("FAIL sb_id_inst got %h exp %h", id_inst, e.id_inst); end
         checks++; if (id_valid !== e.id_valid) begin errors++; $display("FAIL sb_id_valid got %b exp %b", id_valid, e.id_valid); end
         checks++; if (bubble_cnt !== e.bub) begin errors++; $display("FAIL sb_bubble_cnt got %0d exp %0d", bubble_cnt, e.bub); end
         checks++; if (imem_addr !== e.pc[7:2]) begin errors++; $display("FAIL sb_imem_addr got %h exp %h", imem_addr, e.pc[7:2]); end
      end
   end

   task automatic reset_model();
      m = '{pc: 32'h40, id_pc: 32'h0, id_pc4: 32'h0, id_inst: NOP, id_valid: 1'b0, bub: 16'h0};
   endtask

   // drive one cycle, push expected post-edge state, return 2 time units after the edge
   task automatic step(input logic s, input logic [1:0] sel, input logic [31:0] tgt);
      st_t n;
      stall    = s;
      pcsource = sel;
      bpc = (sel == 2'b01) ? tgt : 32'hBAD0_0104;
      jpc = (sel == 2'b10) ? tgt : 32'hBAD0_0208;
      rpc = (sel == 2'b11) ? tgt : 32'hBAD0_030C;
      n = m;
      if (!s) begin
         n.pc     = (sel == 2'b00) ? m.pc + 32'd4 : (tgt & ~32'd3);
         n.id_pc  = m.pc;
         n.id_pc4 = m.pc + 32'd4;
`ifdef IF_FLUSH_EN
         if (sel != 2'b00) begin
            n.id_inst  = NOP;
            n.id_valid = 1'b0;
            n.bub      = (m.bub == 16'hFFFF) ? m.bub : m.bub + 16'd1;
         end else begin
            n.id_inst  = word_at(m.pc[7:2]);
            n.id_valid = 1'b1;
         end
`else
         n.id_inst  = word_at(m.pc[7:2]);
         n.id_valid = 1'b1;
`endif
      end
      q.push_back(n);
      m = n;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      stall = 1'b0; pcsource = 2'b00;
      clr = 1'b1;
      #1;
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rst_pc got %h exp 40", pc); end
      checks++; if (id_pc !== 32'h0 || id_pc4 !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h/%h exp 0/0", id_pc, id_pc4); end
      checks++; if (id_inst !== NOP || id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_inst got %h/%b exp %h/0", id_inst, id_valid, NOP); end
      checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL rst_bubble got %0d exp 0", bubble_cnt); end
      checks++; if (imem_addr !== 6'h10) begin errors++; $display("FAIL rst_imem_addr got %h exp 10", imem_addr); end
      @(negedge clk);
      clr = 1'b0;
      reset_model();
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'b00, 32'h0);
         checks++; if (pc !== 32'h44 + 32'(4*k)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'h44 + 32'(4*k)); end
         checks++; if (id_pc !== 32'h40 + 32'(4*k)) begin errors++; $display("FAIL seq_id_pc got %h exp %h", id_pc, 32'h40 + 32'(4*k)); end
         checks++; if (id_valid !== 1'b1 || bubble_cnt !== 16'h0) begin errors++; $display("FAIL seq_valid got %b/%0d exp 1/0", id_valid, bubble_cnt); end
      end
   endtask

   task automatic test_stall();
      logic [31:0] h_id_pc, h_inst;
      step(1'b0, 2'b10, 32'h08);
      h_id_pc = m.id_pc; h_inst = m.id_inst;
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 2'b00, 32'h0);
         checks++; if (pc !== 32'h08) begin errors++; $display("FAIL stall_pc got %h exp 08", pc); end
         checks++; if (id_pc !== h_id_pc || id_inst !== h_inst) begin errors++; $display("FAIL stall_id got %h/%h exp %h/%h", id_pc, id_inst, h_id_pc, h_inst); end
      end
      step(1'b0, 2'b00, 32'h0);
      checks++; if (pc !== 32'h0C || id_pc !== 32'h08) begin errors++; $display("FAIL stall_resume got %h/%h exp 0c/08", pc, id_pc); end
   endtask

   task automatic test_branch();
      logic [15:0] b0;
      step(1'b0, 2'b10, 32'h10);
      b0 = m.bub;
      step(1'b0, 2'b01, 32'h23);
      checks++; if (pc !== 32'h20 || id_pc !== 32'h10) begin errors++; $display("FAIL br_pc got %h/%h exp 20/10", pc, id_pc); end
`ifdef IF_FLUSH_EN
      checks++; if (id_inst !== NOP || id_valid !== 1'b0) begin errors++; $display("FAIL br_flush got %h/%b exp %h/0", id_inst, id_valid, NOP); end
      checks++; if (bubble_cnt !== b0 + 16'd1) begin errors++; $display("FAIL br_bubble got %0d exp %0d", bubble_cnt, b0 + 16'd1); end
`else
      checks++; if (id_inst !== word_at(6'h04) || id_valid !== 1'b1) begin errors++; $display("FAIL br_slot got %h/%b exp %h/1", id_inst, id_valid, word_at(6'h04)); end
      checks++; if (bubble_cnt !== b0) begin errors++; $display("FAIL br_bubble got %0d exp %0d", bubble_cnt, b0); end
`endif
   endtask

   task automatic test_stall_redirect();
      logic [31:0] p0;
      p0 = m.pc;
      step(1'b1, 2'b10, 32'h80);
      checks++; if (pc !== p0) begin errors++; $display("FAIL sr_hold got %h exp %h", pc, p0); end
      step(1'b0, 2'b10, 32'h80);
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL sr_apply got %h exp 80", pc); end
   endtask

   task automatic test_wrap();
      step(1'b0, 2'b11, 32'hFFFF_FFFE);
      checks++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 6'h3F) begin errors++; $display("FAIL wrap32_top got %h/%h exp fffffffc/3f", pc, imem_addr); end
      step(1'b0, 2'b00, 32'h0);
      checks++; if (pc !== 32'h0 || imem_addr !== 6'h00 || id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap32 got %h/%h/%h exp 0/0/0", pc, imem_addr, id_pc4); end
      @(negedge clk);
      clr = 1'b1;
      #1;
      checks++; if (pc8 !== 8'hF8 || imem_addr8 !== 6'h3E) begin errors++; $display("FAIL wrap8_rst got %h/%h exp f8/3e", pc8, imem_addr8); end
      clr = 1'b0;
      reset_model();
      step(1'b0, 2'b00, 32'h0);
      checks++; if (pc8 !== 8'hFC || imem_addr8 !== 6'h3F) begin errors++; $display("FAIL wrap8_fc got %h/%h exp fc/3f", pc8, imem_addr8); end
      step(1'b0, 2'b00, 32'h0);
      checks++; if (pc8 !== 8'h00 || imem_addr8 !== 6'h00) begin errors++; $display("FAIL wrap8_00 got %h/%h exp 00/00", pc8, imem_addr8); end
   endtask

   task automatic test_async_clr();
      step(1'b0, 2'b01, 32'h100);
      stall = 1'b0; pcsource = 2'b10; jpc = 32'h80;
      #2;
      clr = 1'b1;
      #1;
      checks++; if (pc !== 32'h40 || id_pc !== 32'h0 || id_pc4 !== 32'h0) begin errors++; $display("FAIL aclr_pc got %h/%h/%h exp 40/0/0", pc, id_pc, id_pc4); end
      checks++; if (id_inst !== NOP || id_valid !== 1'b0 || bubble_cnt !== 16'h0) begin errors++; $display("FAIL aclr_id got %h/%b/%0d exp %h/0/0", id_inst, id_valid, bubble_cnt, NOP); end
      @(posedge clk);
      #2;
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL aclr_noredirect got %h exp 40", pc); end
      pcsource = 2'b00;
      clr = 1'b0;
      reset_model();
      step(1'b0, 2'b00, 32'h0);
      checks++; if (pc !== 32'h44 || id_inst !== word_at(6'h10) || id_valid !== 1'b1) begin errors++; $display("FAIL aclr_first got %h/%h/%b exp 44/%h/1", pc, id_inst, id_valid, word_at(6'h10)); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch();
      test_stall_redirect();
      test_wrap();
      test_async_clr();
      @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
